// File: rtl/interpolator.sv
// Rate-up converter: one sample per INT_RATE cycles in, full-rate zero-stuffed out.
// Define INTERP_HOLD_EN for zero-order hold instead of zero-stuffing.
module interpolator #(
  parameter int WIDTH    = 1,
  parameter int INT_RATE = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             clk_slow,
  output logic             underrun
);

  localparam int CW = $clog2(INT_RATE);
  localparam logic [CW-1:0] LAST = CW'(INT_RATE - 1);
  localparam logic [CW-1:0] HALF = CW'(INT_RATE / 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STARVE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             clk_slow_q, clk_slow_d;
  logic             underrun_q, underrun_d;
  logic             last;
  logic             xfer;

  assign last     = (cnt_q == LAST);
  assign xfer     = in_valid & last;
  assign in_ready = last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= LAST;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      clk_slow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      clk_slow_q  <= clk_slow_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = last ? '0 : cnt_q + CW'(1);
`ifdef INTERP_HOLD_EN
    out_d       = out_q;
`else
    out_d       = '0;
`endif
    out_valid_d = (state_q == RUN);
    underrun_d  = 1'b0;
    clk_slow_d  = (cnt_d < HALF);

    // Frame boundary: the next frame is RUN exactly when a sample is taken now.
    if (last) begin
      out_valid_d = xfer;
      if (xfer) out_d = in;
      unique case (state_q)
        IDLE:    state_d = xfer ? RUN : IDLE;
        RUN: begin
          state_d    = xfer ? RUN : STARVE;
          underrun_d = ~xfer;
        end
        STARVE:  state_d = xfer ? RUN : STARVE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign clk_slow  = clk_slow_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_interpolator.sv
// Directed bench for interpolator, WIDTH=8, INT_RATE=4.
// Expectations follow INTERP_HOLD_EN when the bench is built with it.
module tb_interpolator;

`ifdef INTERP_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] din;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dout;
  logic       out_valid;
  logic       clk_slow;
  logic       underrun;

  int n_tests = 0;
  int n_fail  = 0;

  interpolator #(.WIDTH(8), .INT_RATE(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in       (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (dout),
    .out_valid(out_valid),
    .clk_slow (clk_slow),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, " out"}, 32'(dout), 32'h0);
    check({tag, " out_valid"}, 32'(out_valid), 32'h0);
    check({tag, " clk_slow"}, 32'(clk_slow), 32'h0);
    check({tag, " underrun"}, 32'(underrun), 32'h0);
    check({tag, " in_ready"}, 32'(in_ready), 32'h1);
  endtask

  logic [7:0] smp [4];
  logic [7:0] fill;

  initial begin
    smp[0] = 8'h11; smp[1] = 8'h22; smp[2] = 8'h33; smp[3] = 8'hA5;
    rstn = 1'b0; in_valid = 1'b0; din = 8'h00;
    repeat (3) step();
    chk_idle("rst");

    // Release: first cycle already ready
    rstn = 1'b1;
    check("first ready", 32'(in_ready), 32'h1);
    din = smp[0]; in_valid = 1'b1;

    // Continuous stream 11,22,33 then A5
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        fill = (c == 0 || HOLD) ? smp[f] : 8'h00;
        check($sformatf("strm f%0d c%0d out", f, c), 32'(dout), 32'(fill));
        check($sformatf("strm f%0d c%0d vld", f, c), 32'(out_valid), 32'h1);
        check($sformatf("strm f%0d c%0d slow", f, c), 32'(clk_slow),
              32'(c < 2));
        check($sformatf("strm f%0d c%0d rdy", f, c), 32'(in_ready),
              32'(c == 3));
        check($sformatf("strm f%0d c%0d und", f, c), 32'(underrun), 32'h0);
        if (c == 3 && f < 3) din = smp[f+1];
        if (f == 3 && c == 0) in_valid = 1'b0;
      end
    end

    // Two starved frames
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        fill = HOLD ? 8'hA5 : 8'h00;
        check($sformatf("stv f%0d c%0d und", f, c), 32'(underrun),
              32'(f == 0 && c == 0));
        check($sformatf("stv f%0d c%0d vld", f, c), 32'(out_valid), 32'h0);
        check($sformatf("stv f%0d c%0d out", f, c), 32'(dout), 32'(fill));
        if (f == 1 && c == 3) begin
          din = 8'h5A; in_valid = 1'b1;
        end
      end
    end
    step();
    check("resume out", 32'(dout), 32'h5A);
    check("resume vld", 32'(out_valid), 32'h1);
    check("resume und", 32'(underrun), 32'h0);
    in_valid = 1'b0;
    step();
    check("resume c1 out", 32'(dout), 32'(HOLD ? 8'h5A : 8'h00));

    // Handshake: valid raised at cnt=1, captured only at cnt=3
    din = 8'hC3; in_valid = 1'b1;
    step();
    check("hs c2 rdy", 32'(in_ready), 32'h0);
    check("hs c2 out", 32'(dout), 32'(HOLD ? 8'h5A : 8'h00));
    step();
    check("hs c3 rdy", 32'(in_ready), 32'h1);
    check("hs c3 out", 32'(dout), 32'(HOLD ? 8'h5A : 8'h00));
    din = 8'h7E;
    step();
    check("hs no early cap", 32'(dout), 32'h7E);
    din = 8'hC3;
    check("hs vld", 32'(out_valid), 32'h1);

    // Reset mid-operation right after accepting a sample
    repeat (3) step();
    din = 8'h7E;
    @(posedge clk);
    #1;
    rstn = 1'b0; in_valid = 1'b0;
    #1;
    chk_idle("mid rst");
    step();
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("post c%0d out", c), 32'(dout), 32'h0);
      check($sformatf("post c%0d vld", c), 32'(out_valid), 32'h0);
      check($sformatf("post c%0d und", c), 32'(underrun), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
